systolic_mm_seq: RTL and testbench

//   Parametrised N x N output-stationary systolic matrix multiplier with a built-in sequencer.

---
 rtl/systolic_mm_seq_if.sv | 30 +++
 rtl/systolic_mm_seq.sv | 239 +++++++++++++++++++++++
 tb/tb_systolic_mm_seq.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_mm_seq_if.sv
// Load/readout stream bundle for systolic_mm_seq.
// The master drives operand beats and out_ready; the slave (the array) drives everything else.
interface systolic_mm_seq_if #(
   parameter int unsigned N          = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 32
);
   localparam int unsigned RowW = (N > 1) ? $clog2(N) : 1;

   logic                             load_valid;
   logic                             load_ready;
   logic [N-1:0][DATA_WIDTH-1:0]     a_in;
   logic [N-1:0][DATA_WIDTH-1:0]     b_in;
   logic                             busy;
   logic                             out_valid;
   logic                             out_ready;
   logic [N-1:0][ACC_WIDTH-1:0]      c_out;
   logic [RowW-1:0]                  out_row;
   logic                             done;

   modport master (
      output load_valid, a_in, b_in, out_ready,
      input  load_ready, busy, out_valid, c_out, out_row, done
   );

   modport slave (
      input  load_valid, a_in, b_in, out_ready,
      output load_ready, busy, out_valid, c_out, out_row, done
   );
endinterface

// File: rtl/systolic_mm_seq.sv
// N x N output-stationary systolic matrix multiplier (C = A x B, signed) with load/compute/read FSM.
// Define SYSTOLIC_SAT_EN to make each accumulator clamp (sticky) instead of wrapping.
module systolic_mm_seq #(
   parameter int unsigned N          = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ACC_WIDTH  = 32
) (
   input logic              clk,
   input logic              rst,
   systolic_mm_seq_if.slave bus
);

   localparam int unsigned RowW = $clog2(N);
   localparam int unsigned CycW = $clog2(3 * N - 2);
   localparam int unsigned PW   = 2 * DATA_WIDTH;

   localparam logic [RowW-1:0] LastIdx = RowW'(N - 1);
   localparam logic [CycW-1:0] LastCyc = CycW'(3 * N - 3);

   if (ACC_WIDTH < 2 * DATA_WIDTH) begin : g_acc_width_check
      $error("systolic_mm_seq: ACC_WIDTH must be at least 2*DATA_WIDTH");
   end
   if (N < 2) begin : g_dim_check
      $error("systolic_mm_seq: N must be at least 2");
   end

   typedef enum logic [1:0] {StLoad, StCompute, StRead} state_e;

   state_e                          state_q, state_d;
   logic [RowW-1:0]                 beat_q, beat_d;
   logic [CycW-1:0]                 cyc_q, cyc_d;
   logic [RowW-1:0]                 row_q, row_d;
   logic [RowW-1:0]                 row_sel;
   logic                            done_q, done_d;
   logic [N-1:0][ACC_WIDTH-1:0]     c_out_q;

   logic                            load_hs;
   logic                            start;
   logic                            compute_en;
   logic                            capture;

   logic signed [DATA_WIDTH-1:0]    a_buf_q  [N][N];  // [row i][beat k] = A[i][k]
   logic signed [DATA_WIDTH-1:0]    b_buf_q  [N][N];  // [beat k][col j] = B[k][j]
   logic signed [DATA_WIDTH-1:0]    a_feed   [N];
   logic signed [DATA_WIDTH-1:0]    b_feed   [N];
   logic signed [DATA_WIDTH-1:0]    a_left   [N][N];
   logic signed [DATA_WIDTH-1:0]    b_top    [N][N];
   logic signed [DATA_WIDTH-1:0]    a_pipe_q [N][N];
   logic signed [DATA_WIDTH-1:0]    b_pipe_q [N][N];
   logic signed [PW-1:0]            prod     [N][N];
   logic signed [ACC_WIDTH-1:0]     prod_ext [N][N];
   logic signed [ACC_WIDTH-1:0]     acc_q    [N][N];
   logic signed [ACC_WIDTH-1:0]     acc_d    [N][N];
`ifdef SYSTOLIC_SAT_EN
   localparam logic [ACC_WIDTH-1:0] AccMax = {1'b0, {(ACC_WIDTH - 1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] AccMin = {1'b1, {(ACC_WIDTH - 1){1'b0}}};
   logic                            ovf      [N][N];
   logic                            sat_q    [N][N];
`endif

   // ---------------------------------------------------------------- control FSM
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      cyc_d      = cyc_q;
      row_d      = row_q;
      row_sel    = row_q;
      done_d     = 1'b0;
      load_hs    = 1'b0;
      start      = 1'b0;
      compute_en = 1'b0;
      capture    = 1'b0;
      unique case (state_q)
         StLoad: begin
            if (bus.load_valid) begin
               load_hs = 1'b1;
               beat_d  = beat_q + RowW'(1);
               if (beat_q == LastIdx) begin
                  beat_d  = '0;
                  start   = 1'b1;
                  state_d = StCompute;
               end
            end
         end
         StCompute: begin
            compute_en = 1'b1;
            cyc_d      = cyc_q + CycW'(1);
            if (cyc_q == LastCyc) begin
               // Row 0 settled long before the last wavefront reaches PE(N-1,N-1).
               cyc_d   = '0;
               capture = 1'b1;
               row_sel = '0;
               state_d = StRead;
            end
         end
         StRead: begin
            if (bus.out_ready) begin
               if (row_q == LastIdx) begin
                  row_d   = '0;
                  done_d  = 1'b1;
                  state_d = StLoad;
               end else begin
                  row_d   = row_q + RowW'(1);
                  row_sel = row_q + RowW'(1);
                  capture = 1'b1;
               end
            end
         end
         default: state_d = StLoad;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= StLoad;
         beat_q  <= '0;
         cyc_q   <= '0;
         row_q   <= '0;
         done_q  <= 1'b0;
         c_out_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         cyc_q   <= cyc_d;
         row_q   <= row_d;
         done_q  <= done_d;
         if (capture) begin
            for (int j = 0; j < N; j++) c_out_q[j] <= acc_q[row_sel][j];
         end
      end
   end

   assign bus.load_ready = (state_q == StLoad);
   assign bus.busy       = (state_q != StLoad);
   assign bus.out_valid  = (state_q == StRead);
   assign bus.out_row    = row_q;
   assign bus.c_out      = c_out_q;
   assign bus.done       = done_q;

   // ---------------------------------------------------------------- operand buffers
   always_ff @(posedge clk) begin
      if (load_hs) begin
         for (int j = 0; j < N; j++) begin
            a_buf_q[j][beat_q] <= bus.a_in[j];
            b_buf_q[beat_q][j] <= bus.b_in[j];
         end
      end
   end

   // Edge feed at cycle t: row i gets A[i][t-i], column j gets B[t-j][j], zero outside the window.
   always_comb begin
      logic [CycW-1:0] k;
      k = '0;
      for (int i = 0; i < N; i++) begin
         a_feed[i] = '0;
         b_feed[i] = '0;
         if (cyc_q >= CycW'(i)) begin
            k = cyc_q - CycW'(i);
            if (k < CycW'(N)) begin
               a_feed[i] = a_buf_q[i][k[RowW-1:0]];
               b_feed[i] = b_buf_q[k[RowW-1:0]][i];
            end
         end
      end
   end

   // ---------------------------------------------------------------- PE array
   for (genvar i = 0; i < N; i++) begin : g_row
      for (genvar j = 0; j < N; j++) begin : g_col
         if (j == 0) begin : g_a_edge
            assign a_left[i][j] = a_feed[i];
         end else begin : g_a_chain
            assign a_left[i][j] = a_pipe_q[i][j-1];
         end
         if (i == 0) begin : g_b_edge
            assign b_top[i][j] = b_feed[j];
         end else begin : g_b_chain
            assign b_top[i][j] = b_pipe_q[i-1][j];
         end

         assign prod[i][j]     = PW'(a_left[i][j]) * PW'(b_top[i][j]);
         assign prod_ext[i][j] = ACC_WIDTH'(prod[i][j]);

`ifdef SYSTOLIC_SAT_EN
         logic [ACC_WIDTH:0] wide;
         assign wide = {acc_q[i][j][ACC_WIDTH-1], acc_q[i][j]}
                     + {prod_ext[i][j][ACC_WIDTH-1], prod_ext[i][j]};
         assign ovf[i][j] = wide[ACC_WIDTH] ^ wide[ACC_WIDTH-1];
         // Once clamped, the PE holds its rail for the rest of the computation.
         assign acc_d[i][j] = sat_q[i][j] ? acc_q[i][j]
                            : ovf[i][j]   ? (wide[ACC_WIDTH] ? AccMin : AccMax)
                            : wide[ACC_WIDTH-1:0];
`else
         assign acc_d[i][j] = acc_q[i][j] + prod_ext[i][j];
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_pipe_q[i][j] <= '0;
               b_pipe_q[i][j] <= '0;
            end
         end
      end else if (compute_en) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               a_pipe_q[i][j] <= a_left[i][j];
               b_pipe_q[i][j] <= b_top[i][j];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || start) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= '0;
`ifdef SYSTOLIC_SAT_EN
               sat_q[i][j] <= 1'b0;
`endif
            end
         end
      end else if (compute_en) begin
         for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
               acc_q[i][j] <= acc_d[i][j];
`ifdef SYSTOLIC_SAT_EN
               sat_q[i][j] <= sat_q[i][j] | ovf[i][j];
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_systolic_mm_seq.sv
// Directed bench for systolic_mm_seq: table of matrix products plus reset/latency/handshake corners.
// A second 16-bit-accumulator instance runs in lockstep to cover overflow behaviour.
module tb_systolic_mm_seq;
   localparam int N   = 8;
   localparam int DW  = 8;
   localparam int AW  = 32;
   localparam int AWN = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   systolic_mm_seq_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW))  bus   ();
   systolic_mm_seq_if #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AWN)) bus_n ();

   assign bus_n.load_valid = bus.load_valid;
   assign bus_n.a_in       = bus.a_in;
   assign bus_n.b_in       = bus.b_in;
   assign bus_n.out_ready  = bus.out_ready;

   systolic_mm_seq #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   systolic_mm_seq #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(AWN)) dut_n (
      .clk (clk),
      .rst (rst),
      .bus (bus_n)
   );

   typedef struct packed {
      logic [N-1:0][N-1:0][DW-1:0] a;    // a[i][k]
      logic [N-1:0][N-1:0][DW-1:0] b;    // b[k][j]
      logic [N-1:0][N-1:0][AW-1:0] c;    // expected C[i][j]
      logic [3:0]                  gap;  // idle cycles between load beats
      logic                        bp;   // alternate out_ready 0/1
      logic                        chk_n;
      logic [AWN-1:0]              c_n;  // every element of the 16-bit instance
   } vec_t;

   localparam int NumVec = 8;
   vec_t vecs [NumVec];

   int checks   = 0;
   int failures = 0;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [N*AW-1:0] act,
                        input logic [N*AW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic load(input vec_t v);
      for (int k = 0; k < N; k++) begin
         if (k == N - 1) check("busy_before_last_beat", {bus.busy, bus.load_ready}, 2'b01);
         bus.load_valid = 1'b1;
         for (int j = 0; j < N; j++) begin
            bus.a_in[j] = v.a[j][k];
            bus.b_in[j] = v.b[k][j];
         end
         tick();
         bus.load_valid = 1'b0;
         if (k < N - 1) repeat (int'(v.gap)) tick();
      end
   endtask

   task automatic run_case(input vec_t v);
      int  lat;
      int  row;
      int  cyc;
      logic rdy;
      load(v);
      check("compute_flags", {bus.busy, bus.load_ready, bus.out_valid}, 3'b100);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      check("first_valid_latency", lat, 23);
      row = 0;
      cyc = 0;
      while (row < N && cyc < 4 * N) begin
         check("out_valid", bus.out_valid, 1'b1);
         if (!bus.out_valid) break;
         check("out_row", bus.out_row, row);
         check("c_out_row", bus.c_out, v.c[row]);
         if (v.chk_n) check("c_out_acc16", bus_n.c_out, {N{v.c_n}});
         rdy = v.bp ? cyc[0] : 1'b1;
         bus.out_ready = rdy;
         tick();
         cyc++;
         if (rdy) begin
            row++;
            check("done_on_handshake", bus.done, row == N);
         end else begin
            check("done_while_stalled", bus.done, 1'b0);
         end
      end
      bus.out_ready = 1'b0;
      check("rows_handshaken", row, N);
      check("post_read_flags", {bus.out_valid, bus.busy, bus.load_ready}, 3'b001);
      tick();
      check("done_single_pulse", bus.done, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.load_valid = 1'b0;
      bus.a_in       = '0;
      bus.b_in       = '0;
      bus.out_ready  = 1'b0;

      for (int v = 0; v < NumVec; v++) vecs[v] = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            // identity x ramp
            vecs[0].a[i][j] = (i == j) ? 8'd1 : 8'd0;
            vecs[0].b[i][j] = DW'(i * 8 + j + 1);
            vecs[0].c[i][j] = AW'(i * 8 + j + 1);
            // all -128 x all -128
            vecs[1].a[i][j] = 8'h80;
            vecs[1].b[i][j] = 8'h80;
            vecs[1].c[i][j] = AW'(131072);
            // all 1 x ramp: sum_k (8k + j + 1) = 8j + 232
            vecs[4].a[i][j] = 8'd1;
            vecs[4].b[i][j] = DW'(i * 8 + j + 1);
            vecs[4].c[i][j] = AW'(8 * j + 232);
            // -identity x ramp
            vecs[5].a[i][j] = (i == j) ? 8'hFF : 8'd0;
            vecs[5].b[i][j] = DW'(i * 8 + j + 1);
            vecs[5].c[i][j] = AW'(-(i * 8 + j + 1));
            // all 127 x all 127: 8 * 16129
            vecs[6].a[i][j] = 8'd127;
            vecs[6].b[i][j] = 8'd127;
            vecs[6].c[i][j] = AW'(129032);
            // all -128 x all 127: 8 * -16256
            vecs[7].a[i][j] = 8'h80;
            vecs[7].b[i][j] = 8'd127;
            vecs[7].c[i][j] = AW'(-130048);
         end
      end
      vecs[2]    = vecs[0];
      vecs[2].bp = 1'b1;
      vecs[3]     = vecs[0];
      vecs[3].gap = 4'd2;
      vecs[5].bp  = 1'b1;
      vecs[5].gap = 4'd1;
      vecs[1].chk_n = 1'b1;
      vecs[6].chk_n = 1'b1;
      vecs[7].chk_n = 1'b1;
`ifdef SYSTOLIC_SAT_EN
      vecs[1].c_n = AWN'(32767);
      vecs[6].c_n = AWN'(32767);
      vecs[7].c_n = AWN'(-32768);
`else
      vecs[1].c_n = AWN'(0);
      vecs[6].c_n = AWN'(-2040);
      vecs[7].c_n = AWN'(1024);
`endif

      repeat (2) tick();
      check("reset_flags", {bus.load_ready, bus.out_valid, bus.busy, bus.done}, 4'b1000);
      check("reset_out_row", bus.out_row, 0);
      check("reset_c_out", bus.c_out, '0);
      rst = 1'b1;

      // out_ready in LOAD must not move the readout pointer
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check("out_ready_ignored", {bus.out_valid, bus.out_row}, '0);

      for (int v = 0; v < NumVec; v++) run_case(vecs[v]);

      // Reset five cycles into COMPUTE, then a clean identity run
      load(vecs[0]);
      repeat (4) tick();
      check("midop_busy", bus.busy, 1'b1);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      check("midop_reset_flags", {bus.load_ready, bus.out_valid, bus.busy, bus.done}, 4'b1000);
      check("midop_reset_c_out", bus.c_out, '0);
      run_case(vecs[0]);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
